// File: rtl/modn_div_50dc.sv
// Programmable mod-N clock divider, 50% duty for both even and odd N.
// Ports: clk, reset_L, en, div_in, div_load -> clk_out, tc, div_busy, div_err.
module modn_div_50dc #(
  parameter int W           = 8,
  parameter int DIV_DEFAULT = 2
) (
  input  logic         clk,
  input  logic         reset_L,
  input  logic         en,
  input  logic [W-1:0] div_in,
  input  logic         div_load,
  output logic         clk_out,
  output logic         tc,
  output logic         div_busy,
  output logic         div_err
);

  localparam logic [W-1:0] DEF = W'(DIV_DEFAULT);
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] TWO = W'(2);

  logic [W-1:0] cnt;
  logic [W-1:0] div_n;
  logic [W-1:0] div_p;
  logic         ph_p;
  logic         ph_n;
  logic         busy_q;
  logic         err_q;

  logic         wrap;
  logic         bnd;
  logic         swap;
  logic         load_ok;
  logic         load_bad;
  logic [W-1:0] n_eff;
  logic [W-1:0] cnt_nx;
  logic [W:0]   half;

  // The period starting on a swap edge already uses the pending divisor
  // for its phase threshold.
  always_comb begin
    wrap     = (cnt == div_n - ONE);
    bnd      = en & wrap;
    swap     = bnd & busy_q;
    n_eff    = swap ? div_p : div_n;
    cnt_nx   = wrap ? '0 : cnt + ONE;
    half     = ({1'b0, n_eff} + {{W{1'b0}}, 1'b1}) >> 1;
    load_ok  = div_load & (div_in >= TWO);
    load_bad = div_load & (div_in < TWO);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt    <= DEF - ONE;
      div_n  <= DEF;
      div_p  <= DEF;
      ph_p   <= 1'b0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= load_bad;
      if (en) begin
        cnt  <= cnt_nx;
        ph_p <= ({1'b0, cnt_nx} < half);
      end
      if (swap) begin
        div_n  <= div_p;
        busy_q <= 1'b0;
      end
      // A load on the swap edge becomes the next pending value.
      if (load_ok) begin
        div_p  <= div_in;
        busy_q <= 1'b1;
      end
    end
  end

  // Half-cycle delayed copy of the phase; ANDed in for odd N.
  always_ff @(negedge clk or negedge reset_L) begin
    if (!reset_L) ph_n <= 1'b0;
    else          ph_n <= ph_p;
  end

  assign clk_out  = div_n[0] ? (ph_p & ph_n) : ph_p;
  assign tc       = reset_L & bnd;
  assign div_busy = busy_q;
  assign div_err  = err_q;

endmodule

// File: tb/tb_modn_div_50dc.sv
// Self-checking bench for modn_div_50dc, period-position reference model.
// Drives directed scenarios then randomized loads/enables.
module tb_modn_div_50dc;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       en;
  logic       div_load;
  logic [7:0] div_in;
  wire        clk_out;
  wire        tc;
  wire        div_busy;
  wire        div_err;

  always #5 clk = ~clk;

  modn_div_50dc #(.W(8), .DIV_DEFAULT(2)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .en      (en),
    .div_in  (div_in),
    .div_load(div_load),
    .clk_out (clk_out),
    .tc      (tc),
    .div_busy(div_busy),
    .div_err (div_err)
  );

  int n_chk;
  int n_pass;

  int m_pos;
  int m_N;
  int m_P;
  bit m_busy;
  bit m_err;
  bit m_frozen;

  logic obs_a, obs_b, obs_tc, obs_busy, obs_err;
  logic exp_a, exp_b, exp_tc;

  task automatic model_reset();
    m_N      = 2;
    m_P      = 2;
    m_pos    = 1;
    m_busy   = 0;
    m_err    = 0;
    m_frozen = 1;
  endtask

  // One clk cycle: update the model at the rising edge, sample the DUT
  // in the high half (a) and the low half (b).
  task automatic step();
    bit l_en, ld;
    int din;
    @(posedge clk);
    l_en = en;
    ld   = div_load;
    din  = int'(div_in);
    m_err = ld && (din < 2);
    if (l_en) begin
      if (m_pos == m_N - 1) begin
        if (m_busy) begin
          m_N    = m_P;
          m_busy = 0;
        end
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end
    if (ld && din >= 2) begin
      m_P    = din;
      m_busy = 1;
    end
    m_frozen = !l_en;
    #1;
    obs_a    = clk_out;
    obs_err  = div_err;
    obs_busy = div_busy;
    exp_b = (m_pos < (m_N + 1) / 2);
    if (m_N % 2 == 0)  exp_a = (m_pos < m_N / 2);
    else if (m_frozen) exp_a = exp_b;
    else               exp_a = (m_pos >= 1) && exp_b;
    @(negedge clk);
    #1;
    obs_b  = clk_out;
    obs_tc = tc;
    exp_tc = en && (m_pos == m_N - 1);
  endtask

  task automatic test_reset();
    reset_L  = 1'b0;
    en       = 1'b0;
    div_load = 1'b0;
    div_in   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (clk_out !== 1'b0) $display("FAIL reset_clk_out got=%b exp=0", clk_out);
    else n_pass++;
    n_chk++;
    if (tc !== 1'b0) $display("FAIL reset_tc got=%b exp=0", tc);
    else n_pass++;
    n_chk++;
    if (div_busy !== 1'b0 || div_err !== 1'b0)
      $display("FAIL reset_flags got=%b%b exp=00", div_busy, div_err);
    else n_pass++;
    @(negedge clk);
    reset_L = 1'b1;
    #1;
    n_chk++;
    if (tc !== 1'b0) $display("FAIL reset_tc_en0 got=%b exp=0", tc);
    else n_pass++;
  endtask

  task automatic test_div2();
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_chk++;
      if (obs_a !== logic'(i % 2 == 0) || obs_b !== logic'(i % 2 == 0))
        $display("FAIL div2_clk i=%0d got=%b%b exp=%b", i, obs_a, obs_b, i % 2 == 0);
      else n_pass++;
      n_chk++;
      if (obs_tc !== logic'(i % 2 == 1))
        $display("FAIL div2_tc i=%0d got=%b exp=%b", i, obs_tc, i % 2 == 1);
      else n_pass++;
    end
  endtask

  task automatic test_odd5();
    int k, highs, tcs;
    div_in   = 8'd5;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    n_chk++;
    if (obs_busy !== 1'b1) $display("FAIL odd5_busy got=%b exp=1", obs_busy);
    else n_pass++;
    k = 0;
    while (obs_busy === 1'b1 && k < 10) begin
      step();
      k++;
    end
    n_chk++;
    if (obs_busy !== 1'b0) $display("FAIL odd5_busy_clear got=%b exp=0", obs_busy);
    else n_pass++;
    n_chk++;
    if (obs_a !== 1'b0 || obs_b !== 1'b1)
      $display("FAIL odd5_rise_negedge got=%b%b exp=01", obs_a, obs_b);
    else n_pass++;
    highs = int'(obs_a) + int'(obs_b);
    tcs   = int'(obs_tc);
    for (int i = 1; i < 10; i++) begin
      step();
      if (i < 5) highs += int'(obs_a) + int'(obs_b);
      tcs += int'(obs_tc);
    end
    n_chk++;
    if (highs != 5) $display("FAIL odd5_high_halves got=%0d exp=5", highs);
    else n_pass++;
    n_chk++;
    if (tcs != 2) $display("FAIL odd5_tc_count got=%0d exp=2", tcs);
    else n_pass++;
  endtask

  task automatic test_last_load();
    int k;
    logic prev_tc;
    k = 0;
    while (m_pos != 0 && k < 20) begin
      step();
      k++;
    end
    div_in = 8'd6; div_load = 1'b1; step();
    div_load = 1'b0; step();
    div_in = 8'd3; div_load = 1'b1; step();
    div_load = 1'b0;
    prev_tc = obs_tc;
    k = 0;
    while (obs_busy === 1'b1 && k < 20) begin
      prev_tc = obs_tc;
      step();
      k++;
    end
    n_chk++;
    if (prev_tc !== 1'b1 || obs_busy !== 1'b0)
      $display("FAIL lastload_clear_at_bnd got=%b%b exp=10", prev_tc, obs_busy);
    else n_pass++;
    k = 1;
    while (obs_tc !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    n_chk++;
    if (k != 3) $display("FAIL lastload_period got=%0d exp=3", k);
    else n_pass++;
  endtask

  task automatic test_load_boundary();
    int k;
    div_in = 8'd7; div_load = 1'b1; step();
    div_load = 1'b0;
    k = 0;
    while (m_pos != m_N - 1 && k < 20) begin
      step();
      k++;
    end
    div_in = 8'd4; div_load = 1'b1; step();
    div_load = 1'b0;
    n_chk++;
    if (obs_busy !== 1'b1) $display("FAIL bndload_pending got=%b exp=1", obs_busy);
    else n_pass++;
    k = 1;
    while (obs_tc !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    n_chk++;
    if (k != 7) $display("FAIL bndload_first_period got=%0d exp=7", k);
    else n_pass++;
    step();
    n_chk++;
    if (obs_busy !== 1'b0) $display("FAIL bndload_clear got=%b exp=0", obs_busy);
    else n_pass++;
    k = 1;
    while (obs_tc !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    n_chk++;
    if (k != 4) $display("FAIL bndload_second_period got=%0d exp=4", k);
    else n_pass++;
  endtask

  task automatic test_illegal();
    int k;
    for (int v = 0; v < 2; v++) begin
      div_in = 8'(v); div_load = 1'b1; step();
      div_load = 1'b0;
      n_chk++;
      if (obs_err !== 1'b1 || obs_busy !== 1'b0)
        $display("FAIL illegal_pulse v=%0d got=%b%b exp=10", v, obs_err, obs_busy);
      else n_pass++;
      step();
      n_chk++;
      if (obs_err !== 1'b0) $display("FAIL illegal_one_cycle v=%0d got=%b exp=0", v, obs_err);
      else n_pass++;
    end
    div_in = 8'd9; div_load = 1'b1; step();
    div_in = 8'd1; step();
    div_load = 1'b0;
    n_chk++;
    if (obs_err !== 1'b1 || obs_busy !== 1'b1)
      $display("FAIL illegal_busy got=%b%b exp=11", obs_err, obs_busy);
    else n_pass++;
    k = 0;
    while (obs_busy === 1'b1 && k < 20) begin
      step();
      k++;
    end
    k = 1;
    while (obs_tc !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    n_chk++;
    if (k != 9) $display("FAIL illegal_keeps_p got=%0d exp=9", k);
    else n_pass++;
  endtask

  task automatic test_freeze_reset();
    int k, tcs;
    logic held;
    div_in = 8'd6; div_load = 1'b1; step();
    div_load = 1'b0;
    k = 0;
    while (!(obs_busy === 1'b0 && m_pos == 1) && k < 30) begin
      step();
      k++;
    end
    held = obs_b;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if (obs_a !== held || obs_b !== held || obs_tc !== 1'b0)
        $display("FAIL freeze i=%0d got=%b%b%b exp=%b%b0", i, obs_a, obs_b, obs_tc, held, held);
      else n_pass++;
    end
    en = 1'b1;
    div_in = 8'd8; div_load = 1'b1; step();
    div_load = 1'b0;
    k = 0;
    while (obs_b !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    reset_L = 1'b0;
    #1;
    n_chk++;
    if (clk_out !== 1'b0 || tc !== 1'b0 || div_busy !== 1'b0)
      $display("FAIL async_reset got=%b%b%b exp=000", clk_out, tc, div_busy);
    else n_pass++;
    model_reset();
    @(negedge clk);
    reset_L = 1'b1;
    tcs = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      tcs += int'(obs_tc);
    end
    n_chk++;
    if (tcs != 3) $display("FAIL reset_default_n got=%0d exp=3", tcs);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      div_load = ($urandom_range(0, 6) == 0);
      div_in   = 8'($urandom_range(0, 9));
      step();
      n_chk++;
      if (obs_a !== exp_a || obs_b !== exp_b)
        $display("FAIL rnd_clk i=%0d got=%b%b exp=%b%b", i, obs_a, obs_b, exp_a, exp_b);
      else n_pass++;
      n_chk++;
      if (obs_tc !== exp_tc) $display("FAIL rnd_tc i=%0d got=%b exp=%b", i, obs_tc, exp_tc);
      else n_pass++;
      n_chk++;
      if (obs_busy !== logic'(m_busy) || obs_err !== logic'(m_err))
        $display("FAIL rnd_flags i=%0d got=%b%b exp=%b%b", i, obs_busy, obs_err, m_busy, m_err);
      else n_pass++;
    end
    div_load = 1'b0;
    en = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_div2();
    test_odd5();
    test_last_load();
    test_load_boundary();
    test_illegal();
    test_freeze_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
